// File: rtl/lsu_mem_stage.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage -- memory-access stage of the 4-stage NPC pipeline.
//
// Accepts one execute result per ex_valid/ex_ready handshake. Non-memory
// instructions retire into the WBReg_* register on the accepting edge.
// Loads and stores are issued on a registered valid/ready data-memory port.
// Loads are lane-aligned and sign/zero-extended. Every access, stores
// included, retires when the memory response arrives.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   ex_*                execute-stage payload plus ex_valid / ex_ready
//   dmem_req_*          word-aligned request (addr, we, wdata, wmask) with ready
//   dmem_resp_*         response valid plus read data
//   WBReg_*             write-back pipeline register; WBReg_valid pulses once
//                       per retired instruction
//
// Optional feature (macro LSU_MISALIGN_CHECK_EN):
//   Misaligned H/HU/W accesses are never sent to memory. They retire in one
//   cycle with no register write, and the trap is reported on misalign_trap
//   and misalign_addr. If the macro is undefined, these ports are absent.
// ---------------------------------------------------------------------------
module lsu_mem_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic                  ex_MemRd,
  input  logic                  ex_MemWr,
  input  logic [2:0]            ex_MemOp,
  input  logic [DATA_WIDTH-1:0] ex_ALUout,
  input  logic [DATA_WIDTH-1:0] ex_StoreData,
  input  logic                  ex_MemtoReg,
  input  logic                  ex_RegWr,
  input  logic [ADDR_WIDTH-1:0] ex_Regrd,
  input  logic [DATA_WIDTH-1:0] ex_PC,
  input  logic [DATA_WIDTH-1:0] ex_Instr,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic                  dmem_we,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [3:0]            dmem_wmask,
  input  logic                  dmem_resp_valid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
`ifdef LSU_MISALIGN_CHECK_EN
  output logic                  misalign_trap,
  output logic [DATA_WIDTH-1:0] misalign_addr,
`endif
  output logic                  WBReg_valid,
  output logic                  WBReg_MemtoReg,
  output logic                  WBReg_RegWr,
  output logic [ADDR_WIDTH-1:0] WBReg_Regrd,
  output logic [DATA_WIDTH-1:0] WBReg_ALUout,
  output logic [DATA_WIDTH-1:0] WBReg_DataOut,
  output logic [DATA_WIDTH-1:0] WBReg_PC,
  output logic [DATA_WIDTH-1:0] WBReg_Instr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Byte-enable pattern for a store. BU/HU encodings share the B/H sizes.
  // Every other encoding is treated as a word.
  function automatic logic [3:0] store_mask(input logic [2:0] op, input logic [1:0] a);
    case (op)
      3'b000, 3'b100: store_mask = 4'b0001 << a;
      3'b001, 3'b101: store_mask = a[1] ? 4'b1100 : 4'b0011;
      default:        store_mask = 4'b1111;
    endcase
  endfunction

  // Store data replicated across lanes so that the mask alone selects the bytes.
  function automatic logic [31:0] store_wdata(input logic [2:0] op, input logic [31:0] d);
    case (op)
      3'b000, 3'b100: store_wdata = {4{d[7:0]}};
      3'b001, 3'b101: store_wdata = {2{d[15:0]}};
      default:        store_wdata = d;
    endcase
  endfunction

  // Pick the addressed lane out of the read word, then extend it.
  function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] a,
                                               input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      2'd3:    b = rd[31:24];
      default: b = rd[7:0];
    endcase
    h = a[1] ? rd[31:16] : rd[15:0];
    case (op)
      3'b000:  load_extract = {{24{b[7]}}, b};
      3'b100:  load_extract = {24'h000000, b};
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b101:  load_extract = {16'h0000, h};
      default: load_extract = rd;
    endcase
  endfunction

`ifdef LSU_MISALIGN_CHECK_EN
  // Misalignment check: halfwords need addr[0]=0; words (incl. unused encodings) need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] a);
    case (op)
      3'b000, 3'b100: is_misaligned = 1'b0;
      3'b001, 3'b101: is_misaligned = a[0];
      default:        is_misaligned = (a != 2'b00);
    endcase
  endfunction
`endif

  state_e                  state_q, state_d;

  // Request register: the accepted payload that is still needed at retirement
  logic                    req_load_q, req_load_d;
  logic [2:0]              req_memop_q, req_memop_d;
  logic                    req_memtoreg_q, req_memtoreg_d;
  logic                    req_regwr_q, req_regwr_d;
  logic [ADDR_WIDTH-1:0]   req_regrd_q, req_regrd_d;
  logic [DATA_WIDTH-1:0]   req_alu_q, req_alu_d;
  logic [DATA_WIDTH-1:0]   req_pc_q, req_pc_d;
  logic [DATA_WIDTH-1:0]   req_instr_q, req_instr_d;

  logic                    dmem_req_valid_q, dmem_req_valid_d;
  logic                    dmem_we_q, dmem_we_d;
  logic [DATA_WIDTH-1:0]   dmem_addr_q, dmem_addr_d;
  logic [DATA_WIDTH-1:0]   dmem_wdata_q, dmem_wdata_d;
  logic [3:0]              dmem_wmask_q, dmem_wmask_d;

  logic                    wb_valid_q, wb_valid_d;
  logic                    wb_memtoreg_q, wb_memtoreg_d;
  logic                    wb_regwr_q, wb_regwr_d;
  logic [ADDR_WIDTH-1:0]   wb_regrd_q, wb_regrd_d;
  logic [DATA_WIDTH-1:0]   wb_alu_q, wb_alu_d;
  logic [DATA_WIDTH-1:0]   wb_data_q, wb_data_d;
  logic [DATA_WIDTH-1:0]   wb_pc_q, wb_pc_d;
  logic [DATA_WIDTH-1:0]   wb_instr_q, wb_instr_d;

`ifdef LSU_MISALIGN_CHECK_EN
  logic                    trap_q, trap_d;
  logic [DATA_WIDTH-1:0]   trap_addr_q, trap_addr_d;
`endif

  logic                    misalign_s;
  logic                    mem_access_s;

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign_s = (ex_MemRd | ex_MemWr) & is_misaligned(ex_MemOp, ex_ALUout[1:0]);
`else
  assign misalign_s = 1'b0;
`endif
  // A misaligned access is handled as a one-cycle retirement, not a memory op
  assign mem_access_s = (ex_MemRd | ex_MemWr) & ~misalign_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ex_valid && mem_access_s) state_d = ST_REQ;
        else                          state_d = ST_IDLE;
      end
      ST_REQ: begin
        if (dmem_req_ready) state_d = ST_WAIT;
        else                state_d = ST_REQ;
      end
      ST_WAIT: begin
        if (dmem_resp_valid) state_d = ST_IDLE;
        else                 state_d = ST_WAIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath logic: next values of the request, dmem and WBReg registers
  always_comb begin
    req_load_d     = req_load_q;
    req_memop_d    = req_memop_q;
    req_memtoreg_d = req_memtoreg_q;
    req_regwr_d    = req_regwr_q;
    req_regrd_d    = req_regrd_q;
    req_alu_d      = req_alu_q;
    req_pc_d       = req_pc_q;
    req_instr_d    = req_instr_q;
    dmem_req_valid_d = dmem_req_valid_q;
    dmem_we_d        = dmem_we_q;
    dmem_addr_d      = dmem_addr_q;
    dmem_wdata_d     = dmem_wdata_q;
    dmem_wmask_d     = dmem_wmask_q;
    // WBReg_valid and WBReg_RegWr pulse; the rest of the payload holds
    wb_valid_d    = 1'b0;
    wb_regwr_d    = 1'b0;
    wb_memtoreg_d = wb_memtoreg_q;
    wb_regrd_d    = wb_regrd_q;
    wb_alu_d      = wb_alu_q;
    wb_data_d     = wb_data_q;
    wb_pc_d       = wb_pc_q;
    wb_instr_d    = wb_instr_q;
`ifdef LSU_MISALIGN_CHECK_EN
    trap_d      = 1'b0;
    trap_addr_d = trap_addr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          req_load_d     = ex_MemRd;  // MemRd wins when both are set
          req_memop_d    = ex_MemOp;
          req_memtoreg_d = ex_MemtoReg;
          req_regwr_d    = ex_RegWr;
          req_regrd_d    = ex_Regrd;
          req_alu_d      = ex_ALUout;
          req_pc_d       = ex_PC;
          req_instr_d    = ex_Instr;
          if (mem_access_s) begin
            dmem_req_valid_d = 1'b1;
            dmem_we_d        = ~ex_MemRd;
            dmem_addr_d      = {ex_ALUout[DATA_WIDTH-1:2], 2'b00};
            dmem_wdata_d     = store_wdata(ex_MemOp, ex_StoreData);
            dmem_wmask_d     = ex_MemRd ? 4'b0000 : store_mask(ex_MemOp, ex_ALUout[1:0]);
          end else begin
            // Non-memory op, or a trapped access: retire directly
            wb_valid_d    = 1'b1;
            wb_regwr_d    = ex_RegWr & ~misalign_s;
            wb_memtoreg_d = ex_MemtoReg;
            wb_regrd_d    = ex_Regrd;
            wb_alu_d      = ex_ALUout;
            wb_data_d     = {DATA_WIDTH{1'b0}};
            wb_pc_d       = ex_PC;
            wb_instr_d    = ex_Instr;
`ifdef LSU_MISALIGN_CHECK_EN
            if (misalign_s) begin
              trap_d      = 1'b1;
              trap_addr_d = ex_ALUout;
            end else begin
              trap_d      = 1'b0;
            end
`endif
          end
        end else begin
          wb_valid_d = 1'b0;
        end
      end
      ST_REQ: begin
        if (dmem_req_ready) begin
          dmem_req_valid_d = 1'b0;
          dmem_we_d        = 1'b0;
          dmem_wmask_d     = 4'b0000;
        end else begin
          dmem_req_valid_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (dmem_resp_valid) begin
          wb_valid_d    = 1'b1;
          wb_regwr_d    = req_regwr_q & req_load_q;  // stores never write rd
          wb_memtoreg_d = req_memtoreg_q;
          wb_regrd_d    = req_regrd_q;
          wb_alu_d      = req_alu_q;
          wb_data_d     = req_load_q ? load_extract(req_memop_q, req_alu_q[1:0], dmem_rdata)
                                     : {DATA_WIDTH{1'b0}};
          wb_pc_d       = req_pc_q;
          wb_instr_d    = req_instr_q;
        end else begin
          wb_valid_d = 1'b0;
        end
      end
      default: begin
        dmem_req_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset also aborts any in-flight request
  always_ff @(posedge clk) begin
    if (rst) begin
      req_load_q       <= 1'b0;
      req_memop_q      <= 3'b000;
      req_memtoreg_q   <= 1'b0;
      req_regwr_q      <= 1'b0;
      req_regrd_q      <= {ADDR_WIDTH{1'b0}};
      req_alu_q        <= {DATA_WIDTH{1'b0}};
      req_pc_q         <= {DATA_WIDTH{1'b0}};
      req_instr_q      <= {DATA_WIDTH{1'b0}};
      dmem_req_valid_q <= 1'b0;
      dmem_we_q        <= 1'b0;
      dmem_addr_q      <= {DATA_WIDTH{1'b0}};
      dmem_wdata_q     <= {DATA_WIDTH{1'b0}};
      dmem_wmask_q     <= 4'b0000;
      wb_valid_q       <= 1'b0;
      wb_memtoreg_q    <= 1'b0;
      wb_regwr_q       <= 1'b0;
      wb_regrd_q       <= {ADDR_WIDTH{1'b0}};
      wb_alu_q         <= {DATA_WIDTH{1'b0}};
      wb_data_q        <= {DATA_WIDTH{1'b0}};
      wb_pc_q          <= {DATA_WIDTH{1'b0}};
      wb_instr_q       <= {DATA_WIDTH{1'b0}};
`ifdef LSU_MISALIGN_CHECK_EN
      trap_q           <= 1'b0;
      trap_addr_q      <= {DATA_WIDTH{1'b0}};
`endif
    end else begin
      req_load_q       <= req_load_d;
      req_memop_q      <= req_memop_d;
      req_memtoreg_q   <= req_memtoreg_d;
      req_regwr_q      <= req_regwr_d;
      req_regrd_q      <= req_regrd_d;
      req_alu_q        <= req_alu_d;
      req_pc_q         <= req_pc_d;
      req_instr_q      <= req_instr_d;
      dmem_req_valid_q <= dmem_req_valid_d;
      dmem_we_q        <= dmem_we_d;
      dmem_addr_q      <= dmem_addr_d;
      dmem_wdata_q     <= dmem_wdata_d;
      dmem_wmask_q     <= dmem_wmask_d;
      wb_valid_q       <= wb_valid_d;
      wb_memtoreg_q    <= wb_memtoreg_d;
      wb_regwr_q       <= wb_regwr_d;
      wb_regrd_q       <= wb_regrd_d;
      wb_alu_q         <= wb_alu_d;
      wb_data_q        <= wb_data_d;
      wb_pc_q          <= wb_pc_d;
      wb_instr_q       <= wb_instr_d;
`ifdef LSU_MISALIGN_CHECK_EN
      trap_q           <= trap_d;
      trap_addr_q      <= trap_addr_d;
`endif
    end
  end

  assign ex_ready       = (state_q == ST_IDLE);
  assign dmem_req_valid = dmem_req_valid_q;
  assign dmem_we        = dmem_we_q;
  assign dmem_addr      = dmem_addr_q;
  assign dmem_wdata     = dmem_wdata_q;
  assign dmem_wmask     = dmem_wmask_q;
  assign WBReg_valid    = wb_valid_q;
  assign WBReg_MemtoReg = wb_memtoreg_q;
  assign WBReg_RegWr    = wb_regwr_q;
  assign WBReg_Regrd    = wb_regrd_q;
  assign WBReg_ALUout   = wb_alu_q;
  assign WBReg_DataOut  = wb_data_q;
  assign WBReg_PC       = wb_pc_q;
  assign WBReg_Instr    = wb_instr_q;
`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign_trap  = trap_q;
  assign misalign_addr  = trap_addr_q;
`endif

endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, ex_MemRd, ex_MemWr;
  logic [2:0]  ex_MemOp;
  logic [31:0] ex_ALUout, ex_StoreData, ex_PC, ex_Instr;
  logic        ex_MemtoReg, ex_RegWr;
  logic [4:0]  ex_Regrd;
  logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_resp_valid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wmask;
  logic        WBReg_valid, WBReg_MemtoReg, WBReg_RegWr;
  logic [4:0]  WBReg_Regrd;
  logic [31:0] WBReg_ALUout, WBReg_DataOut, WBReg_PC, WBReg_Instr;
`ifdef LSU_MISALIGN_CHECK_EN
  logic        misalign_trap;
  logic [31:0] misalign_addr;
`endif

  typedef struct packed {
    logic        memtoreg;
    logic        regwr;
    logic [4:0]  regrd;
    logic [31:0] aluout;
    logic [31:0] dataout;
    logic [31:0] pc;
    logic [31:0] instr;
  } wb_t;

  wb_t         exp_q[$];
  wb_t         mon_exp, mon_obs;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  lsu_mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_MemRd(ex_MemRd), .ex_MemWr(ex_MemWr),
    .ex_MemOp(ex_MemOp), .ex_ALUout(ex_ALUout), .ex_StoreData(ex_StoreData),
    .ex_MemtoReg(ex_MemtoReg), .ex_RegWr(ex_RegWr), .ex_Regrd(ex_Regrd),
    .ex_PC(ex_PC), .ex_Instr(ex_Instr),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wmask(dmem_wmask), .dmem_resp_valid(dmem_resp_valid), .dmem_rdata(dmem_rdata),
`ifdef LSU_MISALIGN_CHECK_EN
    .misalign_trap(misalign_trap), .misalign_addr(misalign_addr),
`endif
    .WBReg_valid(WBReg_valid), .WBReg_MemtoReg(WBReg_MemtoReg), .WBReg_RegWr(WBReg_RegWr),
    .WBReg_Regrd(WBReg_Regrd), .WBReg_ALUout(WBReg_ALUout), .WBReg_DataOut(WBReg_DataOut),
    .WBReg_PC(WBReg_PC), .WBReg_Instr(WBReg_Instr)
  );

  always #5 clk = ~clk;

  // Scoreboard: every retirement is popped and compared at the falling edge
  always @(negedge clk) begin
    if (WBReg_valid === 1'b1) begin
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL wb_unexpected observed=retirement expected=none alu=%h", WBReg_ALUout);
      end
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        mon_obs = '{memtoreg: WBReg_MemtoReg, regwr: WBReg_RegWr, regrd: WBReg_Regrd,
                    aluout: WBReg_ALUout, dataout: WBReg_DataOut, pc: WBReg_PC,
                    instr: WBReg_Instr};
        vectors++;
        assert (mon_obs === mon_exp) else begin
          miscompares++;
          $error("FAIL wb_payload observed=%h expected=%h", mon_obs, mon_exp);
        end
      end
    end else begin
      vectors++;
      assert (WBReg_RegWr === 1'b0) else begin
        miscompares++;
        $error("FAIL wb_regwr_qual observed=%b expected=0", WBReg_RegWr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one ALU op for a single cycle (ex_valid left high for back-to-back use)
  task automatic alu_op(input logic [31:0] res, input logic [4:0] rd_idx);
    wb_t e;
    pc_ctr = pc_ctr + 32'd4;
    ex_valid = 1'b1; ex_MemRd = 1'b0; ex_MemWr = 1'b0; ex_MemOp = 3'b000;
    ex_ALUout = res; ex_StoreData = 32'h5555_5555; ex_MemtoReg = 1'b0; ex_RegWr = 1'b1;
    ex_Regrd = rd_idx; ex_PC = pc_ctr; ex_Instr = {pc_ctr[15:0], 16'h0033};
    e = '{memtoreg: 1'b0, regwr: 1'b1, regrd: rd_idx, aluout: res, dataout: 32'h0,
          pc: pc_ctr, instr: {pc_ctr[15:0], 16'h0033}};
    exp_q.push_back(e);
    tick();
  endtask

  // Full load/store transaction with programmable ready and response delays
  task automatic mem_op(input string tag, input logic rd, input logic wr, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input int rdy_dly, input int rsp_dly, input logic [31:0] rdata,
                        input logic [31:0] exp_addr, input logic [3:0] exp_mask,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_data);
    wb_t e;
    pc_ctr = pc_ctr + 32'd4;
    chk({tag, "_ex_ready_idle"}, {31'd0, ex_ready}, 32'd1);
    ex_valid = 1'b1; ex_MemRd = rd; ex_MemWr = wr; ex_MemOp = op; ex_ALUout = addr;
    ex_StoreData = sdata; ex_MemtoReg = rd; ex_RegWr = 1'b1; ex_Regrd = 5'd9;
    ex_PC = pc_ctr; ex_Instr = {pc_ctr[15:0], 16'h0003};
    e = '{memtoreg: rd, regwr: rd, regrd: 5'd9, aluout: addr, dataout: exp_data,
          pc: pc_ctr, instr: {pc_ctr[15:0], 16'h0003}};
    exp_q.push_back(e);
    tick();
    ex_valid = 1'b0;
    chk({tag, "_req_valid"}, {31'd0, dmem_req_valid}, 32'd1);
    chk({tag, "_ex_ready_busy"}, {31'd0, ex_ready}, 32'd0);
    chk({tag, "_addr"}, dmem_addr, exp_addr);
    chk({tag, "_we"}, {31'd0, dmem_we}, {31'd0, ~rd});
    if (!rd) begin
      chk({tag, "_wmask"}, {28'd0, dmem_wmask}, {28'd0, exp_mask});
      chk({tag, "_wdata"}, dmem_wdata, exp_wdata);
    end
    for (int i = 0; i < rdy_dly; i++) begin
      tick();
      chk({tag, "_req_hold_valid"}, {31'd0, dmem_req_valid}, 32'd1);
      chk({tag, "_req_hold_addr"}, dmem_addr, exp_addr);
      chk({tag, "_req_hold_we"}, {31'd0, dmem_we}, {31'd0, ~rd});
      chk({tag, "_req_hold_ready"}, {31'd0, ex_ready}, 32'd0);
    end
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    chk({tag, "_req_dropped"}, {31'd0, dmem_req_valid}, 32'd0);
    for (int i = 0; i < rsp_dly; i++) begin
      tick();
      chk({tag, "_wait_no_wb"}, {31'd0, WBReg_valid}, 32'd0);
      chk({tag, "_wait_ex_ready"}, {31'd0, ex_ready}, 32'd0);
    end
    dmem_resp_valid = 1'b1; dmem_rdata = rdata;
    tick();
    dmem_resp_valid = 1'b0; dmem_rdata = 32'h0;
    chk({tag, "_retired"}, {31'd0, WBReg_valid}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_MemRd = 1'b0; ex_MemWr = 1'b0; ex_MemOp = 3'b000;
    ex_ALUout = 32'h0; ex_StoreData = 32'h0; ex_MemtoReg = 1'b0; ex_RegWr = 1'b0;
    ex_Regrd = 5'd0; ex_PC = 32'h0; ex_Instr = 32'h0;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_rdata = 32'h0;
    tick(); tick();
    chk("rst_wb_valid", {31'd0, WBReg_valid}, 32'd0);
    chk("rst_wb_alu", WBReg_ALUout, 32'h0);
    chk("rst_wb_data", WBReg_DataOut, 32'h0);
    chk("rst_wb_pc", WBReg_PC, 32'h0);
    chk("rst_req_valid", {31'd0, dmem_req_valid}, 32'd0);
    chk("rst_we", {31'd0, dmem_we}, 32'd0);
    chk("rst_wmask", {28'd0, dmem_wmask}, 32'd0);
    chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    rst = 1'b0;
    tick();

    // ALU op: latency one, no DataOut, then RegWr drops with valid
    alu_op(32'h0000_1234, 5'd5);
    ex_valid = 1'b0;
    chk("alu_valid", {31'd0, WBReg_valid}, 32'd1);
    chk("alu_aluout", WBReg_ALUout, 32'h0000_1234);
    chk("alu_dataout", WBReg_DataOut, 32'h0);
    tick();
    chk("alu_pulse_end", {31'd0, WBReg_valid}, 32'd0);
    chk("alu_regwr_end", {31'd0, WBReg_RegWr}, 32'd0);

    // Back-to-back ALU ops retire one per cycle
    alu_op(32'hAAAA_0001, 5'd1);
    chk("b2b_1", {31'd0, WBReg_valid}, 32'd1);
    alu_op(32'hAAAA_0002, 5'd2);
    chk("b2b_2", {31'd0, WBReg_valid}, 32'd1);
    alu_op(32'hAAAA_0003, 5'd3);
    chk("b2b_3", {31'd0, WBReg_valid}, 32'd1);
    chk("b2b_ready", {31'd0, ex_ready}, 32'd1);
    ex_valid = 1'b0;
    tick();

    // Loads: lane selection and extension
    mem_op("lb", 1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 0, 0, 32'h80FF_1122,
           32'h8000_0000, 4'h0, 32'h0, 32'hFFFF_FF80);
    mem_op("lbu", 1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0, 0, 0, 32'h80FF_1122,
           32'h8000_0000, 4'h0, 32'h0, 32'h0000_0080);
    mem_op("lb_pos", 1'b1, 1'b0, 3'b000, 32'h8000_0001, 32'h0, 0, 1, 32'h80FF_1122,
           32'h8000_0000, 4'h0, 32'h0, 32'h0000_0011);
    mem_op("lh_hi", 1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0, 1, 0, 32'h80FF_1122,
           32'h8000_0000, 4'h0, 32'h0, 32'hFFFF_80FF);
    mem_op("lhu_hi", 1'b1, 1'b0, 3'b101, 32'h8000_0002, 32'h0, 0, 0, 32'h80FF_1122,
           32'h8000_0000, 4'h0, 32'h0, 32'h0000_80FF);
    mem_op("lh_lo", 1'b1, 1'b0, 3'b001, 32'h8000_0000, 32'h0, 0, 0, 32'h80FF_1122,
           32'h8000_0000, 4'h0, 32'h0, 32'h0000_1122);

    // Stores: masks, replication, no register write
    mem_op("sb", 1'b0, 1'b1, 3'b000, 32'h8000_0001, 32'h1234_56A5, 0, 0, 32'hFFFF_FFFF,
           32'h8000_0000, 4'b0010, 32'hA5A5_A5A5, 32'h0);
    mem_op("sh", 1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 0, 0, 32'hFFFF_FFFF,
           32'h8000_0000, 4'b1100, 32'hABCD_ABCD, 32'h0);
    mem_op("sw", 1'b0, 1'b1, 3'b010, 32'h8000_0004, 32'hCAFE_F00D, 1, 1, 32'h0,
           32'h8000_0004, 4'b1111, 32'hCAFE_F00D, 32'h0);

    // LW with a stalled request and a late response
    mem_op("lw_stall", 1'b1, 1'b0, 3'b010, 32'h8000_000C, 32'h0, 3, 2, 32'hDEAD_BEEF,
           32'h8000_000C, 4'h0, 32'h0, 32'hDEAD_BEEF);
    // MemRd and MemWr both set behaves as a load
    mem_op("rdwr", 1'b1, 1'b1, 3'b010, 32'h8000_0010, 32'h7777_7777, 0, 0, 32'h1357_9BDF,
           32'h8000_0010, 4'h0, 32'h0, 32'h1357_9BDF);
    // Unused MemOp encoding behaves as a word
    mem_op("op011", 1'b1, 1'b0, 3'b011, 32'h8000_0008, 32'h0, 0, 0, 32'h8642_0F0F,
           32'h8000_0008, 4'h0, 32'h0, 32'h8642_0F0F);

    // Reset while waiting for a response; the stray response must be dropped
    ex_valid = 1'b1; ex_MemRd = 1'b1; ex_MemWr = 1'b0; ex_MemOp = 3'b010;
    ex_ALUout = 32'h8000_0020; ex_RegWr = 1'b1; ex_MemtoReg = 1'b1;
    tick();
    ex_valid = 1'b0;
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    chk("abort_in_wait", {31'd0, ex_ready}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ex_ready", {31'd0, ex_ready}, 32'd1);
    chk("abort_req_valid", {31'd0, dmem_req_valid}, 32'd0);
    chk("abort_wb_valid", {31'd0, WBReg_valid}, 32'd0);
    chk("abort_wb_alu", WBReg_ALUout, 32'h0);
    chk("abort_wb_data", WBReg_DataOut, 32'h0);
    dmem_resp_valid = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
    tick();
    dmem_resp_valid = 1'b0;
    chk("stray_resp_wb", {31'd0, WBReg_valid}, 32'd0);
    chk("stray_resp_req", {31'd0, dmem_req_valid}, 32'd0);
    tick();
    chk("stray_resp_wb2", {31'd0, WBReg_valid}, 32'd0);

    // Normal operation resumes
    alu_op(32'h0000_BEEF, 5'd7);
    ex_valid = 1'b0;
    chk("post_rst_alu", WBReg_ALUout, 32'h0000_BEEF);
    tick();
    mem_op("post_rst_lw", 1'b1, 1'b0, 3'b010, 32'h8000_0024, 32'h0, 0, 0, 32'h0BAD_F00D,
           32'h8000_0024, 4'h0, 32'h0, 32'h0BAD_F00D);

`ifdef LSU_MISALIGN_CHECK_EN
    // Misaligned LW traps in one cycle and never reaches dmem
    begin
      wb_t e;
      pc_ctr = pc_ctr + 32'd4;
      chk("mis_trap_idle", {31'd0, misalign_trap}, 32'd0);
      ex_valid = 1'b1; ex_MemRd = 1'b1; ex_MemWr = 1'b0; ex_MemOp = 3'b010;
      ex_ALUout = 32'h8000_0002; ex_MemtoReg = 1'b1; ex_RegWr = 1'b1; ex_Regrd = 5'd4;
      ex_PC = pc_ctr; ex_Instr = 32'h0000_2003;
      e = '{memtoreg: 1'b1, regwr: 1'b0, regrd: 5'd4, aluout: 32'h8000_0002,
            dataout: 32'h0, pc: pc_ctr, instr: 32'h0000_2003};
      exp_q.push_back(e);
      tick();
      ex_valid = 1'b0;
      chk("mis_no_req", {31'd0, dmem_req_valid}, 32'd0);
      chk("mis_wb_valid", {31'd0, WBReg_valid}, 32'd1);
      chk("mis_trap", {31'd0, misalign_trap}, 32'd1);
      chk("mis_addr", misalign_addr, 32'h8000_0002);
      tick();
      chk("mis_trap_end", {31'd0, misalign_trap}, 32'd0);
      chk("mis_addr_hold", misalign_addr, 32'h8000_0002);
      chk("mis_still_no_req", {31'd0, dmem_req_valid}, 32'd0);
    end
`endif

    tick(); tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Memory-access stage of the 4-stage NPC pipeline. Sits between the execute stage and the write-back stage.
- Takes one execute result per handshake. Loads and stores go through a valid/ready data-memory port; loads are aligned and sign/zero-extended.
- Each retired instruction lands in the WBReg_* pipeline register, which the write-back stage consumes every cycle.

Parameters:
- DATA_WIDTH, 32, datapath/address width (fixed at 32; byte lanes assume 4).
- ADDR_WIDTH, 5, register-file index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_valid  in  1  execute result valid
- ex_ready  out  1  stage can accept (state IDLE)
- ex_MemRd  in  1  load
- ex_MemWr  in  1  store
- ex_MemOp  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ex_ALUout  in  DATA_WIDTH  ALU result / effective address
- ex_StoreData  in  DATA_WIDTH  rs2 data
- ex_MemtoReg, ex_RegWr  in  1 each  WB controls
- ex_Regrd  in  ADDR_WIDTH  destination register
- ex_PC, ex_Instr  in  DATA_WIDTH each  tracing payload
- dmem_req_valid  out  1;  dmem_req_ready  in  1
- dmem_we  out  1;  dmem_addr  out  DATA_WIDTH (word-aligned)
- dmem_wdata  out  DATA_WIDTH;  dmem_wmask  out  4
- dmem_resp_valid  in  1;  dmem_rdata  in  DATA_WIDTH
- WBReg_valid  out  1  one-cycle pulse per retired instruction
- WBReg_MemtoReg, WBReg_RegWr  out  1 each
- WBReg_Regrd  out  ADDR_WIDTH
- WBReg_ALUout, WBReg_DataOut, WBReg_PC, WBReg_Instr  out  DATA_WIDTH each

Behaviour:
- Reset: state=IDLE. All WBReg_* outputs = 0. dmem_req_valid=0, dmem_we=0, dmem_wmask=0.
- FSM states: IDLE, REQ, WAIT.
- IDLE: ex_ready=1. On ex_valid, the payload is latched into an internal request register.
- IDLE, neither MemRd nor MemWr: WBReg_* loaded at the same edge, so WBReg_valid=1 next cycle (latency 1). Stays IDLE.
- IDLE, MemRd or MemWr: go to REQ. dmem_req_valid=1 from the next cycle, driven from registers.
- REQ: dmem_addr = {addr[31:2],2'b00}.
- REQ store masks: SB mask = 1<<addr[1:0], wdata = byte replicated ×4. SH mask = addr[1]?1100:0011, wdata = half replicated ×2. SW mask = 1111.
- REQ: request held stable until dmem_req_ready; then go to WAIT. Same-cycle valid&ready is legal.
- WAIT: on dmem_resp_valid (stores also get a response), load WBReg_* and go to IDLE. WBReg_valid=1 the following cycle.
- Load extraction from dmem_rdata:
  - byte = rdata[8*addr[1:0] +: 8]
  - half = rdata[16*addr[1] +: 16]
  - B/H sign-extend, BU/HU zero-extend, W passes through.
- WBReg_DataOut = extracted load value for loads, 0 otherwise.
- WBReg_ALUout = ex_ALUout unchanged.
- Stores retire with WBReg_RegWr=0 regardless of ex_RegWr.
- WBReg_valid=0 in any cycle with no retirement. WBReg_RegWr is qualified: it is 0 whenever WBReg_valid=0, so WB never writes twice.
- ex_ready=0 in REQ/WAIT. Upstream holds its payload.
- Minimum issue rate: one non-memory instruction per cycle. A memory op costs ≥3 cycles to retire.
- dmem_resp_valid outside WAIT is ignored.
- Reset mid-operation (REQ or WAIT): abort to IDLE next edge, dmem_req_valid drops, the in-flight response is discarded.
- MemRd and MemWr both set: treated as a load.
- Unused MemOp encodings: treated as W.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined: an H/HU access with addr[0]=1, or a W access with addr[1:0]≠0, is never issued to dmem.
  - The stage retires in 1 cycle with WBReg_RegWr=0 and WBReg_DataOut=0.
  - Extra output misalign_trap (1 bit, reset 0) pulses with that WBReg_valid.
  - Extra output misalign_addr (DATA_WIDTH) holds the faulting address until the next trap.
- Not defined: no extra ports. Low address bits beyond lane selection are ignored (W ignores addr[1:0], H ignores addr[0]).

Test Plan:
- ADD-type op, ex_ALUout=0x1234 → next cycle WBReg_valid=1, WBReg_ALUout=0x1234, WBReg_DataOut=0; back-to-back ops retire one per cycle.
- LB addr=0x80000003, rdata=0x80FF1122 → WBReg_DataOut=0xFFFFFF80; LBU same → 0x00000080.
- SH addr=0x80000002, rs2=0x0000ABCD → dmem_wmask=1100, dmem_wdata=0xABCDABCD, dmem_addr=0x80000000; retires with WBReg_RegWr=0.
- LW with dmem_req_ready low 3 cycles, resp 2 cycles later → req fields stable throughout, ex_ready=0, single WBReg_valid pulse, DataOut=rdata.
- rst asserted in WAIT, stray resp_valid the next cycle → no WBReg_valid; outputs zero; next op proceeds normally.
- (LSU_MISALIGN_CHECK_EN) LW addr=0x80000002 → no dmem_req_valid, misalign_trap=1, misalign_addr=0x80000002.
